// File: rtl/uart_rom_loader_pkg.sv
// Shared definitions for the UART ROM boot loader: state encodings,
// default framing constants and the checksum helper.
package uart_rom_loader_pkg;

  localparam int unsigned CLK_FREQ         = 32'd12000000;
  localparam int unsigned BAUD             = 32'd115200;
  localparam int unsigned CLKS_PER_BIT_DEF = CLK_FREQ / BAUD;
  localparam logic [7:0]  SYNC_BYTE_DEF    = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEN0 = 3'd1,
    ST_LEN1 = 3'd2,
    ST_DATA = 3'd3,
    ST_CSUM = 3'd4,
    ST_DONE = 3'd5,
    ST_ERR  = 3'd6
  } boot_state_e;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  // Running 8-bit image checksum: plain modulo-256 addition.
  function automatic logic [7:0] csum_add(input logic [7:0] sum, input logic [7:0] b);
    return sum + b;
  endfunction

endpackage

// File: rtl/uart_rx_8n1.sv
// UART 8N1 receiver: two-flop synchroniser, falling-edge start detection,
// mid-bit start re-check, centre sampling of data (LSB first) and stop bit.
module uart_rx_8n1 import uart_rom_loader_pkg::*; #(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_ferr
);

  localparam int unsigned   CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       byte_q, byte_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;
  logic             rx_meta_q, rx_sync_q, rx_prev_q;

  // Synchronise the asynchronous line; idle level is high so reset to 1.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  // Receiver state and datapath registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      byte_q  <= 8'h00;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      byte_q  <= byte_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  // Bit timing: wait half a bit to confirm the start, then one full bit per sample.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    byte_d  = byte_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_sync_q) begin
          state_d = RX_START;
          cnt_d   = '0;
        end else begin
          state_d = RX_IDLE;
        end
      end
      RX_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d = '0;
          bit_d = 3'd0;
          if (rx_sync_q) begin
            state_d = RX_IDLE;   // glitch, not a real start bit
          end else begin
            state_d = RX_DATA;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      RX_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_sync_q, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = RX_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      RX_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = RX_IDLE;
          if (rx_sync_q) begin
            valid_d = 1'b1;
            byte_d  = shift_q;
          end else begin
            ferr_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = RX_IDLE;
      end
    endcase
  end

  assign rx_byte  = byte_q;
  assign rx_valid = valid_q;
  assign rx_ferr  = ferr_q;

endmodule

// File: rtl/uart_rom_loader.sv
// Serial boot loader: parses SYNC/LEN/DATA/CSUM frames from the UART,
// writes packed little-endian words into the instruction ROM and releases
// the core from reset once the checksum matches.
module uart_rom_loader import uart_rom_loader_pkg::*; #(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int unsigned ADDR_W       = 9,
  parameter int unsigned TIMEOUT_CYC  = 1200000,
  parameter logic [7:0]  SYNC_BYTE    = SYNC_BYTE_DEF
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              uart_rx,
  output logic              rom_wen,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [31:0]       rom_wdata,
  output logic              cpu_resetn,
  output logic              boot_done,
  output logic              boot_err
);

  localparam int unsigned      TMR_W     = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [TMR_W-1:0] TMR_ONE   = TMR_W'(1);
  localparam logic [16:0]      MAX_WORDS = 17'd1 << ADDR_W;
  localparam logic [ADDR_W:0]  IDX_ONE   = (ADDR_W + 1)'(1);

  logic [7:0] rx_byte_s;
  logic       rx_valid_s;
  logic       rx_ferr_s;

  uart_rx_8n1 #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk      (clk),
    .resetn   (resetn),
    .rx       (uart_rx),
    .rx_byte  (rx_byte_s),
    .rx_valid (rx_valid_s),
    .rx_ferr  (rx_ferr_s)
  );

  boot_state_e       state_q, state_d;
  logic [7:0]        len_lo_q, len_lo_d;
  logic [ADDR_W:0]   last_idx_q, last_idx_d;
  logic [ADDR_W:0]   word_idx_q, word_idx_d;
  logic [1:0]        lane_q, lane_d;
  logic [23:0]       word_q, word_d;
  logic [7:0]        sum_q, sum_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic              rom_wen_q, rom_wen_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [31:0]       rom_wdata_q, rom_wdata_d;
  logic              cpu_resetn_q, cpu_resetn_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [16:0]       n_full_s;
  logic              timed_s;
  logic              fault_s;

  // Frame FSM, packer, checksum, timer and registered ROM/status outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      len_lo_q     <= 8'h00;
      last_idx_q   <= '0;
      word_idx_q   <= '0;
      lane_q       <= 2'd0;
      word_q       <= 24'h000000;
      sum_q        <= 8'h00;
      tmr_q        <= '0;
      rom_wen_q    <= 1'b0;
      rom_addr_q   <= '0;
      rom_wdata_q  <= 32'h00000000;
      cpu_resetn_q <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_lo_q     <= len_lo_d;
      last_idx_q   <= last_idx_d;
      word_idx_q   <= word_idx_d;
      lane_q       <= lane_d;
      word_q       <= word_d;
      sum_q        <= sum_d;
      tmr_q        <= tmr_d;
      rom_wen_q    <= rom_wen_d;
      rom_addr_q   <= rom_addr_d;
      rom_wdata_q  <= rom_wdata_d;
      cpu_resetn_q <= cpu_resetn_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  // Next-state logic; a received byte always takes priority over an expiring timer.
  always_comb begin
    state_d     = state_q;
    len_lo_d    = len_lo_q;
    last_idx_d  = last_idx_q;
    word_idx_d  = word_idx_q;
    lane_d      = lane_q;
    word_d      = word_q;
    sum_d       = sum_q;
    rom_wen_d   = 1'b0;
    rom_addr_d  = rom_addr_q;
    rom_wdata_d = rom_wdata_q;
    n_full_s    = {1'b0, rx_byte_s, len_lo_q};
    timed_s     = (state_q == ST_LEN0) || (state_q == ST_LEN1) ||
                  (state_q == ST_DATA) || (state_q == ST_CSUM);
    fault_s     = rx_ferr_s || (tmr_q == TMR_LAST);

    if (timed_s && !rx_valid_s) begin
      tmr_d = tmr_q + TMR_ONE;
    end else begin
      tmr_d = '0;
    end

    case (state_q)
      ST_IDLE: begin
        if (rx_valid_s && (rx_byte_s == SYNC_BYTE)) begin
          state_d = ST_LEN0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LEN0: begin
        if (rx_valid_s) begin
          len_lo_d = rx_byte_s;
          state_d  = ST_LEN1;
        end else if (fault_s) begin
          state_d = ST_ERR;
        end else begin
          state_d = ST_LEN0;
        end
      end
      ST_LEN1: begin
        if (rx_valid_s) begin
          sum_d = 8'h00;
          if (n_full_s > MAX_WORDS) begin
            state_d = ST_ERR;
          end else if (n_full_s == 17'd0) begin
            state_d = ST_CSUM;
          end else begin
            state_d    = ST_DATA;
            word_idx_d = '0;
            lane_d     = 2'd0;
            last_idx_d = n_full_s[ADDR_W:0] - IDX_ONE;
          end
        end else if (fault_s) begin
          state_d = ST_ERR;
        end else begin
          state_d = ST_LEN1;
        end
      end
      ST_DATA: begin
        if (rx_valid_s) begin
          sum_d = csum_add(sum_q, rx_byte_s);
          if (lane_q == 2'd3) begin
            rom_wen_d   = 1'b1;
            rom_wdata_d = {rx_byte_s, word_q};
            rom_addr_d  = word_idx_q[ADDR_W-1:0];
            word_idx_d  = word_idx_q + IDX_ONE;
            lane_d      = 2'd0;
            if (word_idx_q == last_idx_q) begin
              state_d = ST_CSUM;
            end else begin
              state_d = ST_DATA;
            end
          end else begin
            lane_d = lane_q + 2'd1;
            case (lane_q)
              2'd0:    word_d[7:0]   = rx_byte_s;
              2'd1:    word_d[15:8]  = rx_byte_s;
              2'd2:    word_d[23:16] = rx_byte_s;
              default: word_d        = word_q;
            endcase
          end
        end else if (fault_s) begin
          state_d = ST_ERR;
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_CSUM: begin
        if (rx_valid_s) begin
          if (rx_byte_s == sum_q) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_ERR;
          end
        end else if (fault_s) begin
          state_d = ST_ERR;
        end else begin
          state_d = ST_CSUM;
        end
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      ST_ERR: begin
        if (rx_valid_s && (rx_byte_s == SYNC_BYTE)) begin
          state_d = ST_LEN0;
        end else begin
          state_d = ST_ERR;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    cpu_resetn_d = (state_d == ST_DONE);
    done_d       = (state_d == ST_DONE);
    err_d        = (state_d == ST_ERR);
  end

  assign rom_wen    = rom_wen_q;
  assign rom_addr   = rom_addr_q;
  assign rom_wdata  = rom_wdata_q;
  assign cpu_resetn = cpu_resetn_q;
  assign boot_done  = done_q;
  assign boot_err   = err_q;

endmodule

// File: tb/tb_uart_rom_loader.sv
// Self-checking bench for uart_rom_loader: table of directed frames, random
// frames against a byte-stream reference model, and reset/boundary sequences.
module tb_uart_rom_loader;

  localparam int CPB = 8;
  localparam int AW  = 4;
  localparam int TMO = 2000;

  logic          clk = 1'b0;
  logic          resetn = 1'b1;
  logic          uart_rx = 1'b1;
  logic          rom_wen;
  logic [AW-1:0] rom_addr;
  logic [31:0]   rom_wdata;
  logic          cpu_resetn;
  logic          boot_done;
  logic          boot_err;

  always #5 clk = ~clk;

  uart_rom_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(AW), .TIMEOUT_CYC(TMO), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .resetn(resetn), .uart_rx(uart_rx), .rom_wen(rom_wen), .rom_addr(rom_addr),
    .rom_wdata(rom_wdata), .cpu_resetn(cpu_resetn), .boot_done(boot_done), .boot_err(boot_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Write monitor: captures every ROM write and keeps a shadow ROM image.
  logic [AW-1:0] got_addr[$];
  logic [31:0]   got_data[$];
  logic [31:0]   rom_img[16];
  logic          wen_prev = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (rom_wen === 1'b1) begin
        got_addr.push_back(rom_addr);
        got_data.push_back(rom_wdata);
        rom_img[rom_addr] = rom_wdata;
        check("wen_single_cycle", {31'd0, wen_prev}, 32'd0);
      end
      wen_prev = rom_wen;
    end
  end

  // Reference model state (carried across streams until reset).
  logic [3:0]  exp_addr[$];
  logic [31:0] exp_data[$];
  logic        exp_done, exp_err, exp_pending;

  // Parse a byte stream by frame position: writes, final done/err flags.
  task automatic model_run(input logic [7:0] bs[$], input bit ok[$]);
    int pos;
    int n;
    logic [7:0] lo, sum;
    logic [31:0] w;
    exp_addr.delete();
    exp_data.delete();
    pos = -1; n = 0; lo = 8'h00; sum = 8'h00; w = 32'h0;
    foreach (bs[k]) begin
      if (exp_done) continue;
      if (pos < 0) begin
        if (ok[k] && bs[k] == 8'hA5) begin
          pos = 0;
          exp_err = 1'b0;
        end
        continue;
      end
      if (!ok[k]) begin
        exp_err = 1'b1; pos = -1;
        continue;
      end
      if (pos == 0) begin
        lo = bs[k];
      end else if (pos == 1) begin
        n = {bs[k], lo};
        if (n > 16) begin
          exp_err = 1'b1; pos = -1;
          continue;
        end
        sum = 8'h00;
      end else if (pos < 2 + 4 * n) begin
        int d;
        d = pos - 2;
        w[8*(d%4) +: 8] = bs[k];
        sum = sum + bs[k];
        if (d % 4 == 3) begin
          exp_addr.push_back(4'(d / 4));
          exp_data.push_back(w);
        end
      end else begin
        if (bs[k] == sum) exp_done = 1'b1;
        else exp_err = 1'b1;
        pos = -1;
        continue;
      end
      pos++;
    end
    exp_pending = (pos >= 0);
    if (exp_pending) exp_err = 1'b1;
  endtask

  task automatic send_bit(input logic v);
    uart_rx = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop_ok ? 1'b1 : 1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
  endtask

  // Assert reset between clock edges and check every output clears at once.
  task automatic do_reset();
    @(negedge clk);
    #2;
    resetn = 1'b0;
    uart_rx = 1'b1;
    #1;
    check("rst_rom_wen", {31'd0, rom_wen}, 32'd0);
    check("rst_rom_addr", {28'd0, rom_addr}, 32'd0);
    check("rst_rom_wdata", rom_wdata, 32'd0);
    check("rst_cpu_resetn", {31'd0, cpu_resetn}, 32'd0);
    check("rst_boot_done", {31'd0, boot_done}, 32'd0);
    check("rst_boot_err", {31'd0, boot_err}, 32'd0);
    exp_done = 1'b0;
    exp_err = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  // Send a stream, let it settle (past the timeout if a frame is left open), compare.
  task automatic run_stream(input logic [7:0] bs[$], input bit ok[$]);
    got_addr.delete();
    got_data.delete();
    foreach (bs[k]) send_byte(bs[k], ok[k]);
    model_run(bs, ok);
    repeat (exp_pending ? TMO + 200 : 200) @(negedge clk);
    check("write_count", got_addr.size(), exp_addr.size());
    for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
      check("write_addr", {28'd0, got_addr[i]}, {28'd0, exp_addr[i]});
      check("write_data", got_data[i], exp_data[i]);
    end
    check("boot_done", {31'd0, boot_done}, {31'd0, exp_done});
    check("boot_err", {31'd0, boot_err}, {31'd0, exp_err});
    check("cpu_resetn", {31'd0, cpu_resetn}, {31'd0, exp_done});
  endtask

  typedef struct {
    bit               rst;
    int               nb;
    logic [0:23][7:0] b;
    logic [23:0]      bad;
    int               exp_wr;
    logic             exp_done;
    logic             exp_err;
  } vec_t;

  vec_t tbl[7];

  initial begin : main
    logic [7:0] bs[$];
    bit ok[$];
    logic [7:0] sum;
    int n;

    tbl[0] = '{1'b1, 12, {8'hA5,8'h02,8'h00,8'h13,8'h00,8'h00,8'h00,8'h6F,8'h00,8'h00,8'h00,8'h82,96'd0}, 24'd0, 2, 1'b1, 1'b0};
    tbl[1] = '{1'b1, 12, {8'hA5,8'h02,8'h00,8'h13,8'h00,8'h00,8'h00,8'h6F,8'h00,8'h00,8'h00,8'h83,96'd0}, 24'd0, 2, 1'b0, 1'b1};
    tbl[2] = '{1'b0, 12, {8'hA5,8'h02,8'h00,8'h13,8'h00,8'h00,8'h00,8'h6F,8'h00,8'h00,8'h00,8'h82,96'd0}, 24'd0, 2, 1'b1, 1'b0};
    tbl[3] = '{1'b1, 3,  {8'hA5,8'h11,8'h00,168'd0}, 24'd0, 0, 1'b0, 1'b1};
    tbl[4] = '{1'b1, 6,  {8'h00,8'hFF,8'hA5,8'h00,8'h00,8'h00,144'd0}, 24'd0, 0, 1'b1, 1'b0};
    tbl[5] = '{1'b1, 5,  {8'hA5,8'h01,8'h00,8'hDE,8'hAD,152'd0}, 24'd0, 0, 1'b0, 1'b1};
    tbl[6] = '{1'b1, 5,  {8'hA5,8'h01,8'h00,8'hDE,8'h77,152'd0}, 24'h000010, 0, 1'b0, 1'b1};

    exp_done = 1'b0; exp_err = 1'b0; exp_pending = 1'b0;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 7; v++) begin
      if (tbl[v].rst) do_reset();
      bs.delete(); ok.delete();
      for (int k = 0; k < tbl[v].nb; k++) begin
        bs.push_back(tbl[v].b[k]);
        ok.push_back(!tbl[v].bad[k]);
      end
      run_stream(bs, ok);
      check("tbl_writes", got_addr.size(), tbl[v].exp_wr);
      check("tbl_done", {31'd0, boot_done}, {31'd0, tbl[v].exp_done});
      check("tbl_err", {31'd0, boot_err}, {31'd0, tbl[v].exp_err});
      if (v == 0) begin
        check("rom_word0", rom_img[0], 32'h00000013);
        check("rom_word1", rom_img[1], 32'h0000006F);
      end
    end

    // Random frames with junk prefix, bad checksums and framing errors.
    for (int r = 0; r < 8; r++) begin
      do_reset();
      bs.delete(); ok.delete();
      for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
        logic [7:0] jb;
        jb = 8'($urandom_range(0, 255));
        if (jb == 8'hA5) jb = 8'h00;
        bs.push_back(jb); ok.push_back(1'b1);
      end
      n = $urandom_range(0, 3);
      bs.push_back(8'hA5); bs.push_back(8'(n)); bs.push_back(8'h00);
      sum = 8'h00;
      for (int k = 0; k < 4 * n; k++) begin
        logic [7:0] db;
        db = 8'($urandom_range(0, 255));
        bs.push_back(db);
        sum = sum + db;
      end
      bs.push_back(($urandom_range(0, 3) == 0) ? sum + 8'd1 : sum);
      for (int k = 0; k < bs.size(); k++) ok.push_back(1'b1);
      while (ok.size() > bs.size()) void'(ok.pop_front());
      if ($urandom_range(0, 4) == 0) ok[$urandom_range(0, bs.size() - 1)] = 1'b0;
      run_stream(bs, ok);
    end

    // Boundary: N == 2^ADDR_W fills the whole ROM.
    do_reset();
    bs.delete(); ok.delete();
    bs.push_back(8'hA5); bs.push_back(8'd16); bs.push_back(8'h00);
    sum = 8'h00;
    for (int k = 0; k < 64; k++) begin
      logic [7:0] db;
      db = 8'($urandom_range(0, 255));
      bs.push_back(db);
      sum = sum + db;
    end
    bs.push_back(sum);
    for (int k = 0; k < bs.size(); k++) ok.push_back(1'b1);
    run_stream(bs, ok);
    check("full_rom_writes", got_addr.size(), 32'd16);
    check("full_rom_last", rom_img[15], {bs[66], bs[65], bs[64], bs[63]});

    // Reset mid-DATA (one word written, two bytes into the next), then reload.
    do_reset();
    send_byte(8'hA5, 1'b1); send_byte(8'h02, 1'b1); send_byte(8'h00, 1'b1);
    send_byte(8'h44, 1'b1); send_byte(8'h33, 1'b1); send_byte(8'h22, 1'b1); send_byte(8'h11, 1'b1);
    send_byte(8'h55, 1'b1); send_byte(8'h66, 1'b1);
    check("mid_wdata_before_rst", rom_wdata, 32'h11223344);
    do_reset();
    bs.delete(); ok.delete();
    bs = '{8'hA5, 8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h14};
    for (int k = 0; k < bs.size(); k++) ok.push_back(1'b1);
    run_stream(bs, ok);
    check("reload_addr0", rom_img[0], 32'h12345678);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard bound on simulation time.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_rom_loader.md
Name: uart_rom_loader

Overview:
- Serial boot loader that sits directly upstream of the instruction ROM's write port (wen/addr/wdata).
- Receives a firmware image over UART 8N1, packs bytes into 32-bit words and writes them sequentially into the ROM.
- Holds the picoRV32 core in reset until the image is loaded and its checksum verifies.
- Lets firmware be replaced without resynthesis; the $readmemh image stays the power-on default.

Parameters:
CLKS_PER_BIT, 104, clock cycles per UART bit (12 MHz / 115200); minimum 4
ADDR_W, 9, ROM word-address width (9 = 512 words, 8 = 256 words)
TIMEOUT_CYC, 1200000, max idle cycles between bytes once a transfer has started
SYNC_BYTE, 8'hA5, frame start marker

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
uart_rx  in  1  serial input, idle high, asynchronous to clk
rom_wen  out  1  ROM write enable, one-cycle pulse per word
rom_addr  out  ADDR_W  ROM word address
rom_wdata  out  32  ROM write data
cpu_resetn  out  1  core reset, low while loading
boot_done  out  1  image loaded and checksum OK
boot_err  out  1  last transfer failed

Behaviour:
- Reset is asynchronous and active-low on resetn. All flops clear immediately when resetn falls, including mid-transfer.
- Reset values: rom_wen=0, rom_addr=0, rom_wdata=0, cpu_resetn=0, boot_done=0, boot_err=0, FSM=IDLE.
- Receiver:
  - uart_rx passes through a 2-flop synchroniser, then start-bit detection on the falling edge.
  - Start bit is re-checked at CLKS_PER_BIT/2. A high sample is a glitch: return to line idle, no byte.
  - Each data bit is sampled at bit centre, LSB first.
  - Stop bit is sampled. If high, rx_valid pulses 1 cycle with rx_byte. If low, rx_ferr pulses 1 cycle and no byte is delivered.
- Frame format: SYNC_BYTE, LEN_LO, LEN_HI (16-bit word count N), 4*N data bytes (each word little-endian), CSUM.
- CSUM is the 8-bit sum mod 256 of all 4*N data bytes.
- FSM transitions:
  - IDLE: rx_byte==SYNC_BYTE -> LEN0. Any other byte is ignored. rx_ferr is ignored.
  - LEN0 -> LEN1 on a byte.
  - LEN1 on a byte, evaluated against N:
    - N > 2^ADDR_W -> ERR.
    - N == 0 -> CSUM.
    - Otherwise -> DATA; word index and byte lane cleared, running sum cleared.
  - DATA: byte k lands in bits [8k+7:8k] and is added to the running sum. On lane 3, in the next cycle: rom_wen=1, rom_wdata=assembled word, rom_addr=word index (first word at 0). Word index then increments. After word N-1 is written -> CSUM.
  - CSUM: byte == sum -> DONE. Mismatch -> ERR.
  - DONE: cpu_resetn=1 and boot_done=1 from the cycle after CSUM is accepted. All further UART input is ignored until resetn.
  - ERR: boot_err=1, cpu_resetn stays 0. Words already written remain in the ROM. SYNC_BYTE restarts at LEN0 and clears boot_err in the same transition.
- Error sources in LEN0, LEN1, DATA or CSUM: rx_ferr, or TIMEOUT_CYC cycles elapsing with no rx_valid. Both -> ERR.
- rom_wen stays high exactly 1 cycle per word. rom_addr and rom_wdata hold their value between writes.
- Write latency: rom_wen asserts 1 cycle after rx_valid of the 4th byte.
- rx_valid and the timeout expiring in the same cycle: the byte wins and the timer reloads.
- N == 2^ADDR_W is legal and fills the whole ROM. The word index never wraps.

Decomposition:
- Shared package holds:
  - FSM state encoding: IDLE, LEN0, LEN1, DATA, CSUM, DONE, ERR.
  - SYNC_BYTE default.
  - CLKS_PER_BIT derivation constant: CLK_FREQ/BAUD with CLK_FREQ=12000000, BAUD=115200.
- One sub-module: uart_rx_8n1 (params CLKS_PER_BIT; ports clk, resetn, rx, rx_byte, rx_valid, rx_ferr).
- Top contains the frame FSM, word packer, checksum and timeout counter.

Test Plan (CLKS_PER_BIT=8, ADDR_W=4, TIMEOUT_CYC=2000):
1. Send A5 02 00 | 13 00 00 00 | 6F 00 00 00 | 82 -> rom_wen pulses twice: addr0=32'h00000013, addr1=32'h0000006F; then cpu_resetn=1, boot_done=1, boot_err=0.
2. Same frame with CSUM=83 -> both words written, boot_err=1, cpu_resetn=0. Then resend the correct frame -> boot_done=1.
3. A5 11 00 (N=17 > 16) -> boot_err=1, no rom_wen pulse.
4. Bytes 00 FF then A5 00 00 00 -> leading junk ignored, N=0 path, boot_done=1, zero writes.
5. A5 01 00 DE AD, then silence for 2000 cycles -> boot_err=1, no write. A byte with stop bit 0 in DATA -> boot_err=1.
6. Pull resetn low mid-DATA after 2 bytes -> all outputs return to reset values immediately. A full frame then loads starting at addr 0.
